divider_err_monitor: RTL and testbench

- Sequential error-measurement stage placed directly downstream of the 16/8 approximate array dividers.
- Consumes each operand pair together with the approximate quotient and remainder the divider produced.
- Recomputes the exact result with an internal 8-cycle restoring divider and accumulates squared quotient error over a fixed window.
- Reports the window MSE, the maximum absolute error, the mismatch count and the skipped-sample count. These figures feed the delay/MSE heuristic characterisation.

---
 rtl/divider_err_monitor.sv | 187 ++++++++++++++++++
 tb/tb_divider_err_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_err_monitor.sv
// Error monitor for the 16/8 approximate dividers: exact restoring re-division plus windowed
// squared-error statistics. Define DIVIDER_ERR_MONITOR_REM_ERR_EN to also accumulate remainder error.
`timescale 1ns/1ps

module divider_err_monitor #(
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            n,
  input  logic [7:0]             d,
  input  logic [7:0]             q_apx,
  input  logic [7:0]             r_apx,
  output logic                   done,
  output logic [15:0]            mse,
  output logic [7:0]             max_abs_err,
  output logic [WINDOW_LOG2:0]   mismatch_cnt,
  output logic [15:0]            skip_cnt,
  output logic [15:0]            rmse
);

  localparam int unsigned ACC_W = 16 + WINDOW_LOG2;
  localparam int unsigned CNT_W = WINDOW_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << WINDOW_LOG2) - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, DIV, ACC, DONE} state_t;

  state_t             state_q, state_d;
  logic               clear, accept, reject, div_step, acc_step;
  logic               hs, bad_sample;
  logic [7:0]         rem_q, n_lo_q, d_q, qa_q, quo_q;
  logic [2:0]         bit_cnt_q;
  logic [CNT_W-1:0]   sample_cnt_q;
  logic [ACC_W-1:0]   acc_q, acc_sum;
  logic [8:0]         part, diff;
  logic               ge;
  logic [7:0]         q_err;
  logic [15:0]        q_sq;

  // |a - b| with the difference formed as a 9-bit signed value
  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] e;
    e = {1'b0, a} - {1'b0, b};
    return e[8] ? 8'(9'd0 - e) : e[7:0];
  endfunction

  assign hs         = in_valid & in_ready;
  assign bad_sample = (d == 8'd0) || (n[15:8] >= d);

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor
  assign part = {rem_q, n_lo_q[7]};
  assign ge   = part >= {1'b0, d_q};
  assign diff = part - {1'b0, d_q};

  assign q_err   = abs_diff(qa_q, quo_q);
  assign q_sq    = 16'(q_err) * 16'(q_err);
  assign acc_sum = acc_q + ACC_W'(q_sq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    div_step = 1'b0;
    acc_step = 1'b0;
    if (start) begin
      clear   = 1'b1;
      state_d = COLLECT;
    end else begin
      case (state_q)
        IDLE: ;
        COLLECT: begin
          if (hs) begin
            if (bad_sample) begin
              reject = 1'b1;
            end else begin
              accept  = 1'b1;
              state_d = DIV;
            end
          end
        end
        DIV: begin
          div_step = 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ACC;
        end
        ACC: begin
          acc_step = 1'b1;
          state_d  = (sample_cnt_q == LAST_SAMPLE) ? DONE : COLLECT;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef DIVIDER_ERR_MONITOR_REM_ERR_EN
  logic [7:0]       ra_q, r_err;
  logic [15:0]      r_sq;
  logic [ACC_W-1:0] racc_q, racc_sum;

  assign r_err    = abs_diff(ra_q, rem_q);
  assign r_sq     = 16'(r_err) * 16'(r_err);
  assign racc_sum = racc_q + ACC_W'(r_sq);

  // Remainder error accumulator; rem_q holds r_exact once DIV has finished
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q   <= '0;
      racc_q <= '0;
      rmse   <= '0;
    end else if (clear) begin
      racc_q <= '0;
      rmse   <= '0;
    end else if (accept) begin
      ra_q <= r_apx;
    end else if (acc_step) begin
      racc_q <= racc_sum;
      rmse   <= racc_sum[ACC_W-1:WINDOW_LOG2];
    end
  end
`else
  logic unused_r_apx;
  assign unused_r_apx = ^r_apx;
  assign rmse         = '0;
`endif

  // Datapath, statistics and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready     <= 1'b0;
      done         <= 1'b0;
      rem_q        <= '0;
      n_lo_q       <= '0;
      d_q          <= '0;
      qa_q         <= '0;
      quo_q        <= '0;
      bit_cnt_q    <= '0;
      sample_cnt_q <= '0;
      acc_q        <= '0;
      mse          <= '0;
      max_abs_err  <= '0;
      mismatch_cnt <= '0;
      skip_cnt     <= '0;
    end else begin
      in_ready <= (state_d == COLLECT);
      done     <= (state_d == DONE);
      if (clear) begin
        bit_cnt_q    <= '0;
        sample_cnt_q <= '0;
        acc_q        <= '0;
        mse          <= '0;
        max_abs_err  <= '0;
        mismatch_cnt <= '0;
        skip_cnt     <= '0;
      end else if (accept) begin
        rem_q     <= n[15:8];
        n_lo_q    <= n[7:0];
        d_q       <= d;
        qa_q      <= q_apx;
        quo_q     <= '0;
        bit_cnt_q <= '0;
      end else if (reject) begin
        if (skip_cnt != 16'hFFFF) skip_cnt <= skip_cnt + 16'd1;
      end else if (div_step) begin
        rem_q     <= ge ? diff[7:0] : part[7:0];
        quo_q     <= {quo_q[6:0], ge};
        n_lo_q    <= {n_lo_q[6:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end else if (acc_step) begin
        acc_q        <= acc_sum;
        mse          <= acc_sum[ACC_W-1:WINDOW_LOG2];
        sample_cnt_q <= sample_cnt_q + CNT_W'(1);
        if (q_err > max_abs_err) max_abs_err <= q_err;
        if (q_err != 8'd0)       mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_divider_err_monitor.sv
// Bench for divider_err_monitor: transaction-level reference model using plain / and %,
// per-cycle output comparison, directed scenarios with literal expectations and random windows.
`timescale 1ns/1ps

module tb_divider_err_monitor;

  localparam int W = 2;
`ifdef DIVIDER_ERR_MONITOR_REM_ERR_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, done;
  logic [15:0] n, mse, skip_cnt, rmse;
  logic [7:0]  d, q_apx, r_apx, max_abs_err;
  logic [W:0]  mismatch_cnt;

  int checks = 0;
  int errors = 0;

  divider_err_monitor #(.WINDOW_LOG2(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx), .done(done), .mse(mse),
    .max_abs_err(max_abs_err), .mismatch_cnt(mismatch_cnt), .skip_cnt(skip_cnt), .rmse(rmse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sample is accepted when a window is open and no result is pending;
  // its statistics land nine edges later (8 division cycles plus the accumulate cycle).
  int m_sum, m_rsum, m_max, m_mis, m_cnt, m_skip, m_busy;
  int pq_e, pr_e, pq_a, pr_a, me, mer, mabs;
  bit m_active, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || start) begin
      m_sum = 0; m_rsum = 0; m_max = 0; m_mis = 0; m_cnt = 0; m_skip = 0; m_busy = 0;
      m_done = 1'b0;
      m_active = rst_n ? 1'b1 : 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        me   = pq_a - pq_e;
        mer  = pr_a - pr_e;
        mabs = (me < 0) ? -me : me;
        m_sum  += me * me;
        m_rsum += mer * mer;
        if (mabs > m_max) m_max = mabs;
        if (me != 0) m_mis++;
        m_cnt++;
        if (m_cnt == (1 << W)) begin
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
    end else if (m_active && in_valid) begin
      if (d == 0 || (int'(n) / 256) >= int'(d)) begin
        if (m_skip < 65535) m_skip++;
      end else begin
        m_busy = 9;
        pq_e = int'(n) / int'(d);
        pr_e = int'(n) % int'(d);
        pq_a = q_apx;
        pr_a = r_apx;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, (m_active && m_busy == 0) ? 1 : 0);
      chk("done", done, m_done);
      chk("max_abs_err", max_abs_err, m_max);
      chk("mismatch_cnt", mismatch_cnt, m_mis);
      chk("skip_cnt", skip_cnt, m_skip);
      if (m_done) begin
        chk("mse", mse, m_sum >> W);
        chk("rmse", rmse, REM_EN ? (m_rsum >> W) : 0);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present a sample and hold it until the handshake edge; called and returns at a negedge
  task automatic send(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qa,
                      input logic [7:0] ra);
    int k;
    k = 0;
    n = nn; d = dd; q_apx = qa; r_apx = ra; in_valid = 1'b1;
    while (!in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready stayed 0 for %0d cycles, required 1", k);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 16'($urandom); d = 8'($urandom); q_apx = 8'($urandom); r_apx = 8'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done", done, 1);
  endtask

  task automatic random_window();
    int clean, iter, qe, re;
    logic [15:0] gn;
    logic [7:0]  gd, gq, gr;
    clean = 0;
    iter  = 0;
    while (clean < (1 << W) && iter < 50) begin
      iter++;
      gd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (gd != 0 && $urandom_range(0, 7) != 0) gn = {8'($urandom_range(0, int'(gd) - 1)), 8'($urandom)};
      else gn = 16'($urandom);
      if (gd != 0 && gn[15:8] < gd) begin
        clean++;
        qe = int'(gn) / int'(gd);
        re = int'(gn) % int'(gd);
      end else begin
        qe = 0;
        re = 0;
      end
      if ($urandom_range(0, 3) == 0) gq = 8'($urandom);
      else gq = 8'(qe + int'($urandom_range(0, 6)) - 3);
      gr = 8'(re + int'($urandom_range(0, 4)) - 2);
      send(gn, gd, gq, gr);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    n = '0; d = '0; q_apx = '0; r_apx = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_mse", mse, 0);
    chk("rst_skip", skip_cnt, 0);
    chk("rst_rmse", rmse, 0);

    // Exact samples: 100/7 = 14 r 2
    pulse_start();
    repeat (4) send(16'd100, 8'd7, 8'd14, 8'd2);
    wait_done();
    chk("exact_mse", mse, 0);
    chk("exact_max", max_abs_err, 0);
    chk("exact_mis", mismatch_cnt, 0);

    // Signed errors 0,+2,-2,+4: sum 24, mse 6
    pulse_start();
    send(16'd100, 8'd7, 8'd14, 8'd2);
    send(16'd100, 8'd7, 8'd16, 8'd2);
    send(16'd100, 8'd7, 8'd12, 8'd2);
    send(16'd100, 8'd7, 8'd18, 8'd2);
    k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("done_latency", k, 9);
    chk("model_sum", m_sum, 24);
    chk("signed_mse", mse, 6);
    chk("signed_max", max_abs_err, 4);
    chk("signed_mis", mismatch_cnt, 3);

    // Rejections keep the block in COLLECT and do not count as samples
    pulse_start();
    send(16'd100, 8'd0, 8'd1, 8'd1);
    chk("rej1_ready", in_ready, 1);
    send(16'h0900, 8'd9, 8'd1, 8'd1);
    chk("rej2_ready", in_ready, 1);
    chk("rej_skip", skip_cnt, 2);
    repeat (4) send(16'd100, 8'd7, 8'd14, 8'd2);
    wait_done();
    chk("rej_skip_end", skip_cnt, 2);

    // Remainder errors 0,0,0,4 -> 4 when enabled
    pulse_start();
    repeat (3) send(16'd100, 8'd7, 8'd14, 8'd2);
    send(16'd100, 8'd7, 8'd14, 8'd6);
    wait_done();
    chk("rmse_lit", rmse, REM_EN ? 4 : 0);

    // Restart during DIV of sample 3, then start colliding with a COLLECT handshake
    pulse_start();
    send(16'd100, 8'd7, 8'd15, 8'd2);
    send(16'd100, 8'd7, 8'd20, 8'd2);
    send(16'd100, 8'd7, 8'd30, 8'd2);
    repeat (2) @(negedge clk);
    start = 1'b1; in_valid = 1'b1; n = 16'd100; d = 8'd7; q_apx = 8'd200;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("restart_ready", in_ready, 1);
    chk("restart_done", done, 0);
    chk("restart_max", max_abs_err, 0);
    chk("restart_mis", mismatch_cnt, 0);
    start = 1'b1; in_valid = 1'b1; q_apx = 8'd200;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    repeat (4) send(16'd100, 8'd7, 8'd14, 8'd2);
    wait_done();
    chk("collide_mis", mismatch_cnt, 0);
    chk("collide_max", max_abs_err, 0);

    // Reset during DIV cycle 4 clears everything immediately
    pulse_start();
    send(16'd100, 8'd0, 8'd1, 8'd1);
    send(16'd100, 8'd7, 8'd20, 8'd2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ready", in_ready, 0);
    chk("mrst_done", done, 0);
    chk("mrst_skip", skip_cnt, 0);
    chk("mrst_max", max_abs_err, 0);
    chk("mrst_mis", mismatch_cnt, 0);
    chk("mrst_mse", mse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    random_window();

    // Random windows
    for (int w = 0; w < 8; w++) begin
      pulse_start();
      random_window();
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
